// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared bus widths plus arbiter state and owner encodings.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef REG_W
`define REG_W 32
`endif
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RDATA} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_EX} owner_t;
endpackage

// File: rtl/mem_port_arbiter_starve.sv
// arb_starve_counter: counts execute wins while fetch waits and forces fetch at the limit.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic arb_en,
  input  logic if_req,
  input  logic ex_req,
  output logic ex_sel
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  assign ex_sel = ex_req && !(if_req && starve_cnt >= LIM);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) starve_cnt <= '0;
    else if (!if_req || (arb_en && !ex_sel)) starve_cnt <= '0;
    else if (arb_en && starve_cnt < LIM) starve_cnt <= starve_cnt + 4'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and execute, one transaction at a time.
// Define MEM_ARB_PERF_EN to add the perf_if_wait/perf_ex_wait/perf_force counters.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef REG_W
`define REG_W 32
`endif
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  if_req,
  input  logic [`ADDR_W-1:0]    if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [`DATA_W-1:0]    if_rdata,
  input  logic                  ex_req,
  input  logic [`ADDR_W-1:0]    ex_addr,
  input  logic [`DATA_W/8-1:0]  ex_we,
  input  logic [`REG_W-1:0]     ex_wdata,
  output logic                  ex_gnt,
  output logic                  ex_rvalid,
  output logic [`DATA_W-1:0]    ex_rdata,
  output logic                  mem_req,
  output logic [`ADDR_W-1:0]    mem_addr,
  output logic [`DATA_W/8-1:0]  mem_we,
  output logic [`REG_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [`DATA_W-1:0]    mem_rdata,
  output logic                  busy,
  output logic                  timeout_err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_if_wait,
  output logic [31:0]           perf_ex_wait,
  output logic [31:0]           perf_force
`endif
);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
  arb_state_t state, nxt;
  owner_t owner;
  logic [7:0] wait_cnt;
  logic [`DATA_W-1:0] if_rdata_q, ex_rdata_q;
  logic arb_en, ex_sel, gnt, done_rd, tmo;
  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk), .rstn(rstn), .arb_en(arb_en), .if_req(if_req), .ex_req(ex_req), .ex_sel(ex_sel)
  );
  assign arb_en    = state == ARB_IDLE && (if_req || ex_req);
  assign gnt       = state == ARB_REQ && mem_gnt;
  // a load may finish straight from REQ when rvalid arrives with the grant
  assign done_rd   = mem_rvalid && mem_we == '0 && (state == ARB_RDATA || gnt);
  assign tmo       = state != ARB_IDLE && !gnt && !done_rd && wait_cnt == WAIT_LAST;
  assign mem_req   = state == ARB_REQ;
  assign busy      = state != ARB_IDLE;
  assign if_gnt    = gnt && owner == OWN_FETCH;
  assign ex_gnt    = gnt && owner == OWN_EX;
  assign if_rvalid = done_rd && owner == OWN_FETCH;
  assign ex_rvalid = done_rd && owner == OWN_EX;
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign ex_rdata  = ex_rvalid ? mem_rdata : ex_rdata_q;
  always_comb begin
    nxt = state;
    if (arb_en) nxt = ARB_REQ;
    else if (done_rd || (gnt && mem_we != '0) || tmo) nxt = ARB_IDLE;
    else if (gnt) nxt = ARB_RDATA;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= ARB_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      owner       <= OWN_FETCH;
      mem_addr    <= '0;
      mem_we      <= '0;
      mem_wdata   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      if_rdata_q  <= '0;
      ex_rdata_q  <= '0;
    end else begin
      if (arb_en) begin
        owner     <= ex_sel ? OWN_EX : OWN_FETCH;
        mem_addr  <= ex_sel ? ex_addr : if_addr;
        mem_we    <= ex_sel ? ex_we : '0;
        mem_wdata <= ex_sel ? ex_wdata : '0;
      end
      wait_cnt <= (nxt != state || state == ARB_IDLE) ? '0 : wait_cnt + 8'd1;
      if (tmo) timeout_err <= 1'b1;
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (ex_rvalid) ex_rdata_q <= mem_rdata;
    end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      perf_if_wait <= '0;
      perf_ex_wait <= '0;
      perf_force   <= '0;
    end else begin
      perf_if_wait <= perf_if_wait + 32'(if_req && !if_gnt);
      perf_ex_wait <= perf_ex_wait + 32'(ex_req && !ex_gnt);
      perf_force   <= perf_force + 32'(arb_en && if_req && ex_req && !ex_sel);
    end
`endif
endmodule
